// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bus between the requesters, the RAM and ram_arbiter.
//   Requester side : req, wr, access_type (one bit per port), wdata (packed,
//                    port n at [n*DATA_W +: DATA_W]); gnt, done, rdata, busy back.
//   RAM side       : ram_wren, ram_access_type, ram_data_in out of the arbiter,
//                    ram_result back from the RAM.
//   slave  modport : the arbiter.
//   master modport : the environment (requesters plus RAM).
interface ram_arbiter_if #(
  parameter int DATA_W = 48
);
  logic [2:0]          req;
  logic [2:0]          wr;
  logic [2:0]          access_type;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          done;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic                ram_wren;
  logic                ram_access_type;
  logic [DATA_W-1:0]   ram_data_in;
  logic [DATA_W-1:0]   ram_result;

  modport slave (
    input  req, wr, access_type, wdata, ram_result,
    output gnt, done, rdata, busy, ram_wren, ram_access_type, ram_data_in
  );

  modport master (
    output req, wr, access_type, wdata, ram_result,
    input  gnt, done, rdata, busy, ram_wren, ram_access_type, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port scheduler for the shared balance RAM.
// Three requesters (0 = memory init, 1 = transaction, 2 = display) raise level
// requests; one is granted at a time by fixed priority (lowest index wins), a
// single RAM command is issued and the read result is returned with done.
// Ports:
//   i_clock  : system clock, rising edge
//   i_resetn : synchronous active-low reset
//   bus      : ram_arbiter_if.slave (request/grant/done/rdata/busy + RAM side)
// Optional feature (macro ARB_STARVE_GUARD_EN): port 2 wins the next
// arbitration once it has lost STARVE_LIMIT arbitrations in a row.
// All outputs are registered.
module ram_arbiter #(
  parameter int DATA_W       = 48,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         i_clock,
  input  logic         i_resetn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_winner;
  logic                r_wr;
  logic [1:0]          r_lat_cnt;
  logic [2:0]          r_gnt;
  logic [2:0]          r_done;
  logic                r_busy;
  logic                r_ram_wren;
  logic                r_ram_at;
  logic [DATA_W-1:0]   r_ram_din;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_any_req;
  logic [1:0]          w_fixed_winner;
  logic [1:0]          w_winner;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Supported configurations: READ_LATENCY 1..3, STARVE_LIMIT 1..255 (8-bit counter).
  // Any other setting elaborates this marker block so it shows up in the hierarchy.
  if (READ_LATENCY < 1 || READ_LATENCY > 3 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255)
  begin : g_config_out_of_range
  end

  function automatic logic [2:0] f_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    f_onehot = 3'b001;
      2'd1:    f_onehot = 3'b010;
      2'd2:    f_onehot = 3'b100;
      default: f_onehot = 3'b000;
    endcase
  endfunction

  assign w_any_req = |bus.req;

  // Fixed-priority pick; the value is only used when some request is present
  always_comb begin
    w_fixed_winner = 2'd0;
    if (bus.req[0]) begin
      w_fixed_winner = 2'd0;
    end else if (bus.req[1]) begin
      w_fixed_winner = 2'd1;
    end else begin
      w_fixed_winner = 2'd2;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] r_starve_cnt;
  logic       w_force_p2;

  assign w_force_p2 = bus.req[2] && (r_starve_cnt >= 8'(STARVE_LIMIT));
  assign w_winner   = w_force_p2 ? 2'd2 : w_fixed_winner;

  // Starvation counter: counts port-2 losses in IDLE, clears when port 2 wins
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_starve_cnt <= 8'd0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      if (w_winner == 2'd2) begin
        r_starve_cnt <= 8'd0;
      end else if (bus.req[2] && r_starve_cnt != 8'hFF) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_winner = w_fixed_winner;
`endif

  // Write data of the winning port
  always_comb begin
    case (w_winner)
      2'd0:    w_sel_wdata = bus.wdata[0*DATA_W +: DATA_W];
      2'd1:    w_sel_wdata = bus.wdata[1*DATA_W +: DATA_W];
      default: w_sel_wdata = bus.wdata[2*DATA_W +: DATA_W];
    endcase
  end

  // Access FSM with all outputs registered
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state    <= ST_IDLE;
      r_winner   <= 2'd0;
      r_wr       <= 1'b0;
      r_lat_cnt  <= 2'd0;
      r_gnt      <= 3'b000;
      r_done     <= 3'b000;
      r_busy     <= 1'b0;
      r_ram_wren <= 1'b0;
      r_ram_at   <= 1'b0;
      r_ram_din  <= {DATA_W{1'b0}};
      r_rdata    <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            // Command is latched straight into the RAM-facing registers so it
            // is presented during the ISSUE cycle, together with gnt.
            r_state    <= ST_ISSUE;
            r_winner   <= w_winner;
            r_wr       <= bus.wr[w_winner];
            r_gnt      <= f_onehot(w_winner);
            r_busy     <= 1'b1;
            r_ram_wren <= bus.wr[w_winner];
            r_ram_at   <= bus.access_type[w_winner];
            r_ram_din  <= w_sel_wdata;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_gnt      <= 3'b000;
          r_ram_wren <= 1'b0;
          r_lat_cnt  <= 2'(READ_LATENCY);
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 2'd1;
          if (r_lat_cnt == 2'd1) begin
            // ram_result is valid this cycle; writes keep the previous rdata
            if (!r_wr) begin
              r_rdata <= bus.ram_result;
            end else begin
              r_rdata <= r_rdata;
            end
            r_done  <= f_onehot(r_winner);
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          r_done  <= 3'b000;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt      <= 3'b000;
          r_done     <= 3'b000;
          r_busy     <= 1'b0;
          r_ram_wren <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.done            = r_done;
  assign bus.rdata           = r_rdata;
  assign bus.busy            = r_busy;
  assign bus.ram_wren        = r_ram_wren;
  assign bus.ram_access_type = r_ram_at;
  assign bus.ram_data_in     = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter.
// Three DUT instances with READ_LATENCY 1, 2 and 3, each with its own RAM model
// (two words selected by ram_access_type). Stimulus pushes expected grants,
// done pulses and per-cycle output levels into queues; one monitor process
// pops and compares them when the DUT presents an output.
module tb_ram_arbiter;
  localparam int DW = 48;

  typedef struct {
    logic [2:0]    oh;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    int            k;
    int            cyc;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic          busy;
    logic          wren;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } lvl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            rstn_d  [3];
  logic [2:0]      req_d   [3];
  logic [2:0]      wr_d    [3];
  logic [2:0]      at_d    [3];
  logic [3*DW-1:0] wdata_d [3];
  logic            ram_clr;

  logic [2:0]      gnt_w   [3];
  logic [2:0]      done_w  [3];
  logic [DW-1:0]   rdata_w [3];
  logic            busy_w  [3];
  logic            wren_w  [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    ram_arbiter_if #(.DATA_W(DW)) ifc ();
    logic [DW-1:0] mem  [2];
    logic [DW-1:0] pipe [3];

    assign ifc.req         = req_d[gi];
    assign ifc.wr          = wr_d[gi];
    assign ifc.access_type = at_d[gi];
    assign ifc.wdata       = wdata_d[gi];
    assign ifc.ram_result  = pipe[LAT-1];
    assign gnt_w[gi]       = ifc.gnt;
    assign done_w[gi]      = ifc.done;
    assign rdata_w[gi]     = ifc.rdata;
    assign busy_w[gi]      = ifc.busy;
    assign wren_w[gi]      = ifc.ram_wren;

    ram_arbiter #(.DATA_W(DW), .READ_LATENCY(LAT), .STARVE_LIMIT(4)) u_dut (
      .i_clock  (clk),
      .i_resetn (rstn_d[gi]),
      .bus      (ifc)
    );

    // RAM model: synchronous write, read data delayed LAT cycles after the command
    always @(posedge clk) begin
      if (ram_clr) begin
        mem[0] <= 48'h0A0B0C0D0E0F;
        mem[1] <= 48'hCAFE0000BEEF;
      end else if (ifc.ram_wren) begin
        mem[ifc.ram_access_type] <= ifc.ram_data_in;
      end
      pipe[0] <= mem[ifc.ram_access_type];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  // Scoreboard state
  exp_t gnt_q  [3][$];
  exp_t done_q [3][$];
  lvl_t lvl_q  [$];
  int   n_chk = 0;
  int   n_err = 0;
  int   wr_seen [3] = '{0, 0, 0};
  int   exp_wr  [3] = '{0, 0, 0};
  int   timeouts = 0;
  logic fin_req = 1'b0;
  logic fin_ack = 1'b0;

  task automatic chk(input string name, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin : mon
    exp_t e;
    lvl_t l;
    for (int k = 0; k < 3; k++) begin
      if (gnt_w[k] != 3'b000) begin
        if (gnt_q[k].size() == 0) begin
          chk("gnt_unexpected", k, DW'(gnt_w[k]), DW'(0));
        end else begin
          e = gnt_q[k].pop_front();
          chk("gnt_port", k, DW'(gnt_w[k]), DW'(e.oh));
          chk("gnt_cycle", k, DW'(cyc), DW'(e.cyc));
        end
      end
      if (done_w[k] != 3'b000) begin
        if (done_q[k].size() == 0) begin
          chk("done_unexpected", k, DW'(done_w[k]), DW'(0));
        end else begin
          e = done_q[k].pop_front();
          chk("done_port", k, DW'(done_w[k]), DW'(e.oh));
          chk("done_cycle", k, DW'(cyc), DW'(e.cyc));
          chk("done_rdata", k, rdata_w[k], e.data);
        end
      end
      if (wren_w[k]) begin
        wr_seen[k]++;
        chk("wren_outside_issue", k, DW'(gnt_w[k] != 3'b000), DW'(1));
      end
    end
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      l = lvl_q.pop_front();
      chk("lvl_gnt",  l.k, DW'(gnt_w[l.k]),  DW'(l.gnt));
      chk("lvl_done", l.k, DW'(done_w[l.k]), DW'(l.done));
      chk("lvl_busy", l.k, DW'(busy_w[l.k]), DW'(l.busy));
      chk("lvl_wren", l.k, DW'(wren_w[l.k]), DW'(l.wren));
      if (l.chk_rd) chk("lvl_rdata", l.k, rdata_w[l.k], l.rdata);
    end
    if (fin_req && !fin_ack) begin
      for (int k = 0; k < 3; k++) begin
        chk("gnt_missing",  k, DW'(gnt_q[k].size()),  DW'(0));
        chk("done_missing", k, DW'(done_q[k].size()), DW'(0));
        chk("write_count",  k, DW'(wr_seen[k]),       DW'(exp_wr[k]));
      end
      chk("timeouts", 0, DW'(timeouts), DW'(0));
      fin_ack = 1'b1;
    end
  end

  task automatic set_cmd(input int k, input int p, input logic w, input logic a, input logic [DW-1:0] d);
    wr_d[k][p] = w;
    at_d[k][p] = a;
    wdata_d[k][p*DW +: DW] = d;
  endtask

  task automatic expect_gnt(input int k, input int p, input int c);
    exp_t e;
    e.oh = 3'b001 << p;
    e.data = '0;
    e.cyc = c;
    gnt_q[k].push_back(e);
  endtask

  task automatic expect_op(input int k, input int p, input int gc, input int dc, input logic [DW-1:0] rd);
    exp_t e;
    expect_gnt(k, p, gc);
    e.oh = 3'b001 << p;
    e.data = rd;
    e.cyc = dc;
    done_q[k].push_back(e);
  endtask

  task automatic expect_lvl(input int k, input int c, input logic [2:0] g, input logic [2:0] d,
                            input logic b, input logic w, input logic cr, input logic [DW-1:0] rd);
    lvl_t l;
    l.k = k; l.cyc = c; l.gnt = g; l.done = d;
    l.busy = b; l.wren = w; l.chk_rd = cr; l.rdata = rd;
    lvl_q.push_back(l);
  endtask

  // Requester: raise mask, drop each port's req on its done unless held, stop after n_ops dones
  task automatic run_ops(input int k, input logic [2:0] mask, input logic [2:0] hold, input int n_ops, input int budget);
    int seen = 0;
    int t = 0;
    req_d[k] = mask;
    while (seen < n_ops && t < budget) begin
      @(negedge clk);
      t++;
      if (done_w[k] != 3'b000) begin
        seen++;
        req_d[k] = req_d[k] & ~(done_w[k] & ~hold);
      end
    end
    if (seen < n_ops) timeouts++;
    req_d[k] = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  int t0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn_d[k] = 1'b0; req_d[k] = 3'b000; wr_d[k] = 3'b000;
      at_d[k] = 3'b000; wdata_d[k] = '0;
    end
    ram_clr = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    t0 = cyc;
    for (int k = 0; k < 3; k++) expect_lvl(k, t0 + 1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 48'h0);
    @(negedge clk);
    ram_clr = 1'b0;
    for (int k = 0; k < 3; k++) rstn_d[k] = 1'b1;
    @(negedge clk);

    // Single read, port 1, latency 1
    t0 = cyc;
    set_cmd(0, 1, 1'b0, 1'b0, 48'h0);
    expect_op(0, 1, t0 + 1, t0 + 3, 48'h0A0B0C0D0E0F);
    expect_lvl(0, t0 + 1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    expect_lvl(0, t0 + 2, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    expect_lvl(0, t0 + 3, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, 48'h0A0B0C0D0E0F);
    expect_lvl(0, t0 + 4, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 48'h0A0B0C0D0E0F);
    run_ops(0, 3'b010, 3'b000, 1, 20);

    // Port 0 writes word 0 (rdata keeps the last read), then port 1 reads it back
    t0 = cyc;
    set_cmd(0, 0, 1'b1, 1'b0, 48'h112233445566);
    exp_wr[0]++;
    expect_op(0, 0, t0 + 1, t0 + 3, 48'h0A0B0C0D0E0F);
    expect_lvl(0, t0 + 1, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 48'h0);
    expect_lvl(0, t0 + 2, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    run_ops(0, 3'b001, 3'b000, 1, 20);
    t0 = cyc;
    expect_op(0, 1, t0 + 1, t0 + 3, 48'h112233445566);
    run_ops(0, 3'b010, 3'b000, 1, 20);

    // Collision: all three at once; port 2 writes word 1
    t0 = cyc;
    set_cmd(0, 0, 1'b0, 1'b1, 48'h0);
    set_cmd(0, 1, 1'b0, 1'b0, 48'h0);
    set_cmd(0, 2, 1'b1, 1'b1, 48'h5A5A5A5A5A5A);
    exp_wr[0]++;
    expect_op(0, 0, t0 + 1, t0 + 3,  48'hCAFE0000BEEF);
    expect_op(0, 1, t0 + 5, t0 + 7,  48'h112233445566);
    expect_op(0, 2, t0 + 9, t0 + 11, 48'h112233445566);
    run_ops(0, 3'b111, 3'b000, 3, 40);

    // Starvation: all requests held high for five arbitrations
    t0 = cyc;
    set_cmd(0, 2, 1'b0, 1'b0, 48'h0);
    for (int i = 0; i < 4; i++) expect_op(0, 0, t0 + 1 + 4*i, t0 + 3 + 4*i, 48'h5A5A5A5A5A5A);
`ifdef ARB_STARVE_GUARD_EN
    expect_op(0, 2, t0 + 17, t0 + 19, 48'h112233445566);
`else
    expect_op(0, 0, t0 + 17, t0 + 19, 48'h5A5A5A5A5A5A);
`endif
    run_ops(0, 3'b111, 3'b111, 5, 60);

    // Latency 2 and 3 single reads
    t0 = cyc;
    set_cmd(1, 1, 1'b0, 1'b0, 48'h0);
    expect_op(1, 1, t0 + 1, t0 + 4, 48'h0A0B0C0D0E0F);
    expect_lvl(1, t0 + 3, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    run_ops(1, 3'b010, 3'b000, 1, 20);
    t0 = cyc;
    set_cmd(2, 1, 1'b0, 1'b0, 48'h0);
    expect_op(2, 1, t0 + 1, t0 + 5, 48'h0A0B0C0D0E0F);
    expect_lvl(2, t0 + 4, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    run_ops(2, 3'b010, 3'b000, 1, 20);

    // Reset in the second WAIT cycle (latency 3): access dropped, no done
    t0 = cyc;
    set_cmd(2, 2, 1'b0, 1'b1, 48'h0);
    expect_gnt(2, 2, t0 + 1);
    expect_lvl(2, t0 + 2, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 48'h0);
    req_d[2] = 3'b100;
    repeat (3) @(negedge clk);
    rstn_d[2] = 1'b0;
    req_d[2] = 3'b000;
    expect_lvl(2, t0 + 4, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 48'h0);
    @(negedge clk);
    rstn_d[2] = 1'b1;
    repeat (8) @(negedge clk);

    // Recovery read after reset
    t0 = cyc;
    set_cmd(2, 0, 1'b0, 1'b1, 48'h0);
    expect_op(2, 0, t0 + 1, t0 + 5, 48'hCAFE0000BEEF);
    run_ops(2, 3'b001, 3'b000, 1, 20);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Single-port access scheduler for the shared 48-bit balance RAM.
- Three requesters share the RAM: memory init (port 0), transaction store/load (port 1) and money display refresh (port 2).
- Accepts level requests, grants one at a time by fixed priority, issues one RAM command, and returns read data with a done pulse.
- Sits between memory_control / money_display and ram.

Parameters:
- DATA_W, 48, RAM word width.
- READ_LATENCY, 1, clock cycles from RAM command issue to valid ram_result (range 1-3).
- STARVE_LIMIT, 4, lost arbitrations tolerated by port 2 before forced grant (guard builds only).

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- req  in  3  per-port request level; bit0 init, bit1 transaction, bit2 display
- wr  in  3  per-port write flag, 1=write, 0=read
- access_type  in  3  per-port access_type value forwarded to RAM
- wdata  in  3*DATA_W  packed write data; port n at [n*DATA_W +: DATA_W]
- gnt  out  3  one-hot one-cycle pulse when the port's command is accepted
- done  out  3  one-hot one-cycle pulse when the operation completes
- rdata  out  DATA_W  registered read result, valid while done is high and held afterwards
- busy  out  1  high in every state except IDLE
- ram_wren  out  1  RAM write enable
- ram_access_type  out  1  RAM access_type
- ram_data_in  out  DATA_W  RAM write data
- ram_result  in  DATA_W  RAM read output

Behaviour:
- Reset and clocking: one clock; reset is synchronous, active-low (resetn sampled on rising clock).
- Reset values: state=IDLE; gnt=0, done=0, busy=0, ram_wren=0, ram_access_type=0, ram_data_in=0, rdata=0; latency counter=0; starvation counter=0.
- All outputs are registered.
- State IDLE:
  - If any req bit is set, pick the winner: lowest index wins (init > transaction > display).
  - Latch the winner's wr, access_type and wdata.
  - Next state ISSUE; gnt[winner]=1 for exactly the ISSUE cycle.
  - If no request, stay in IDLE.
- State ISSUE (1 cycle):
  - ram_wren = latched wr; ram_access_type and ram_data_in = latched values.
  - Latency counter loads READ_LATENCY; next state WAIT.
- State WAIT:
  - ram_wren=0.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, capture ram_result into rdata (reads only; writes leave rdata unchanged); next state DONE.
- State DONE (1 cycle): done[winner]=1; next state IDLE.
- Timing: req first seen in IDLE at cycle 0 -> gnt at cycle 1 -> done at cycle 2+READ_LATENCY. A back-to-back grant is possible at cycle 4+READ_LATENCY, giving 3+READ_LATENCY cycles per access.
- Handshake rules:
  - The requester holds req, wr, access_type and wdata stable until gnt.
  - The requester deasserts req in the cycle after done, or it is re-arbitrated as a new request.
  - Changes to req during ISSUE, WAIT or DONE are ignored; the latched command is not altered.
- Simultaneous requests in IDLE: only the winner is granted; losers keep req high and compete again at the next IDLE.
- Requests arriving during an operation wait; there is no queueing beyond the level req.
- Reset mid-operation: reset sampled in any state returns to IDLE with the reset values above. An access in progress is dropped without a done pulse. If reset is sampled at the end of IDLE, no RAM write occurs.
- Write through port 2 is legal and treated like any other port.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - An 8-bit starvation counter increments on each IDLE arbitration where req[2]=1 and port 2 loses.
  - The counter clears when port 2 is granted.
  - When counter >= STARVE_LIMIT, port 2 wins the next arbitration regardless of other requests.
- Without the macro: pure fixed priority; the counter logic is absent and the STARVE_LIMIT parameter is unused.

Test Plan:
- Single read: with READ_LATENCY=1, req=3'b010, wr=0, RAM preloaded with 48'h0A0B0C0D0E0F -> gnt=3'b010 at cycle 1; done=3'b010 at cycle 3; rdata=48'h0A0B0C0D0E0F; busy high for cycles 1-3.
- Write then read: port 0 writes 48'h112233445566 (ram_wren high only in the ISSUE cycle); port 1 then reads -> rdata=48'h112233445566.
- Collision: req=3'b111 at the same cycle -> grant order port 0, port 1, port 2, with grants 4 cycles apart (READ_LATENCY=1); each done is one-hot and matches its gnt.
- Starvation (macro on, STARVE_LIMIT=4): req[2] held high while ports 0 and 1 re-request continuously -> port 2 is granted on its 5th arbitration. With the macro off, port 2 is never granted while the higher ports keep requesting.
- Reset mid-WAIT: with READ_LATENCY=3, assert resetn=0 in the second WAIT cycle -> the next cycle is IDLE; gnt, done, busy and ram_wren are 0; no done pulse is ever produced for that access.
- Latency sweep: READ_LATENCY=2 and 3 -> done at cycle 4 and cycle 5 respectively; rdata equals the RAM contents.
